aligned_mem_port: RTL and testbench
===================================

Name: aligned_mem_port

Overview:
- Parametrised, single-port, word-organised RAM with a valid/ready request channel and a registered response channel.
- Supports byte, half, word and (when DATA_W=64) dword accesses. Sub-word writes use byte lanes.
- Each request is checked for bad size, misalignment and out-of-range address. Faulting requests are reported with an error code and never modify memory.
- Serves as the general data-memory endpoint behind core/bus masters; replaces fixed-width 32-bit aligned-write storage.

Parameters:
- DATA_W, 32, word width in bits; legal values 32 or 64.
- ADDR_W, 32, byte-address width.
- DEPTH, 256, number of DATA_W-bit words; power of two.
- ERRCNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address
- req_size  in  2  0=byte, 1=half, 2=word(32b), 3=dword(64b)
- req_wdata  in  DATA_W  write data, right-justified
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  DATA_W  read data, right-justified, zero-extended; 0 for writes and errors
- rsp_error  out  1  request faulted
- rsp_err_code  out  2  0=ok, 1=misaligned, 2=out of range, 3=bad size
- err_count  out  ERRCNT_W  saturating count of faulted requests

Behaviour:
- Reset (async assert, sync deassert): rsp_valid=0, rsp_rdata=0, rsp_error=0, rsp_err_code=0, err_count=0. Memory contents are not reset and are undefined until written.
- req_ready = !rsp_valid || rsp_ready. This is a single-entry response register, so full throughput is one request per cycle when rsp_ready=1.
- Accept: on a clock edge with req_valid && req_ready, the request is processed and the response register is loaded. rsp_valid=1 on the next cycle (1-cycle latency).
- Hold: if rsp_valid && !rsp_ready, the response registers hold, req_ready=0, and no memory access occurs.
- Drain: if rsp_valid && rsp_ready and no new accept, rsp_valid goes to 0. Accept and drain in the same cycle loads the new response; rsp_valid stays 1.
- Offset/index: OFF_W = log2(DATA_W/8); off = req_addr[OFF_W-1:0]; index = req_addr >> OFF_W.
- Checks, first match wins:
  1. Bad size (3): req_size=3 with DATA_W=32.
  2. Misaligned (1): off not a multiple of 2^req_size.
  3. Out of range (2): index >= DEPTH, including any nonzero upper address bits.
- Faulted request: no memory write, rsp_rdata=0, rsp_error=1, err_count += 1, saturating at all-ones.
- Write ok: the bytes off .. off+2^size-1 of word[index] are replaced by the low 2^size bytes of req_wdata. Other bytes are unchanged. rsp_rdata=0.
- Read ok: rsp_rdata = word[index] bytes off .. off+2^size-1, shifted to bit 0 and zero-extended. The read value is sampled at accept time.
- Read-after-write: a read accepted the cycle after a write to the same word returns the written data. No stale forwarding hazard is permitted.
- Reset mid-operation: any pending response is discarded (rsp_valid=0). Memory writes already completed persist.
- Internal structure: the access-size/alignment decoder and the lane-merge logic are combinational. The response register and the error counter are the only sequential state besides the array.

Test Plan:
- DATA_W=32, DEPTH=256. Write word 0x10=0xDEADBEEF, then read word 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err_code=0, rsp_valid one cycle after each accept.
- Byte write 0x11=0xAA, read word 0x10 -> 0xDEADAAEF. Half read 0x12 -> 0x0000DEAD. Byte read 0x13 -> 0x000000DE.
- Word write 0x13=0x12345678 -> rsp_error=1, code=1, err_count=1. Read word 0x10 -> still 0xDEADAAEF. Half read 0x11 -> code=1, err_count=2.
- Word read 0x400 -> code=2. Dword read 0x0 with DATA_W=32 -> code=3, err_count increments. Force err_count to saturate -> holds at 0xFFFF.
- Backpressure: rsp_ready=0 for 3 cycles after a read accept -> rsp_valid stays 1, rsp_rdata stable, req_ready=0. Then rsp_ready=1 with back-to-back requests -> one response per cycle, in order.
- Assert rst_n=0 while rsp_valid=1 -> rsp_valid and err_count go to 0 immediately. Previously written 0x10 still reads 0xDEADAAEF after reset release.

Source files
------------

// File: rtl/aligned_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : aligned_mem_port
// Brief    : Single-port byte-lane RAM with size/alignment/range checking,
//            valid/ready request channel and one-entry registered response.
// Revision : 1.0 - initial release
// ============================================================================
module aligned_mem_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int DEPTH    = 256,
    parameter int ERRCNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_error,
    output logic [1:0]          rsp_err_code,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int c_nb    = DATA_W / 8;
    localparam int c_off_w = $clog2(c_nb);
    localparam int c_idx_w = $clog2(DEPTH);

    localparam logic [1:0] c_code_ok    = 2'd0;
    localparam logic [1:0] c_code_align = 2'd1;
    localparam logic [1:0] c_code_range = 2'd2;
    localparam logic [1:0] c_code_size  = 2'd3;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic                r_rsp_error;
    logic [1:0]          r_rsp_err_code;
    logic [ERRCNT_W-1:0] r_err_count;

    logic                w_accept;
    logic [c_off_w-1:0]  w_off;
    logic [c_idx_w-1:0]  w_index;
    logic [c_off_w+2:0]  w_shamt;
    logic                w_upper_nz;
    logic                w_bad_size;
    logic                w_misaligned;
    logic                w_fault;
    logic [1:0]          w_code;
    logic [2:0]          w_align_mask;
    logic [7:0]          w_be8;
    logic [63:0]         w_dmask64;
    logic [c_nb-1:0]     w_be;
    logic [DATA_W-1:0]   w_cur;
    logic [DATA_W-1:0]   w_wdata_sh;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_rdata;

    assign req_ready = !r_rsp_valid || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    assign w_off   = req_addr[c_off_w-1:0];
    assign w_index = req_addr[c_off_w +: c_idx_w];
    assign w_shamt = {w_off, 3'b000};
    assign w_cur   = r_mem[w_index];

    // Any address bit above the word index means the word lies beyond DEPTH.
    generate
        if (ADDR_W > c_off_w + c_idx_w) begin : g_upper
            assign w_upper_nz = |req_addr[ADDR_W-1:c_off_w+c_idx_w];
        end else begin : g_no_upper
            assign w_upper_nz = 1'b0;
        end
    endgenerate

    always_comb begin
        w_align_mask = 3'b000;
        w_be8        = 8'h01;
        w_dmask64    = 64'h0000_0000_0000_00FF;
        case (req_size)
            2'd0: begin
                w_align_mask = 3'b000;
                w_be8        = 8'h01;
                w_dmask64    = 64'h0000_0000_0000_00FF;
            end
            2'd1: begin
                w_align_mask = 3'b001;
                w_be8        = 8'h03;
                w_dmask64    = 64'h0000_0000_0000_FFFF;
            end
            2'd2: begin
                w_align_mask = 3'b011;
                w_be8        = 8'h0F;
                w_dmask64    = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                w_align_mask = 3'b111;
                w_be8        = 8'hFF;
                w_dmask64    = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase

        w_bad_size   = (req_size == 2'd3) && (DATA_W != 64);
        w_misaligned = |(w_off & w_align_mask[c_off_w-1:0]);

        if (w_bad_size) begin
            w_code = c_code_size;
        end else if (w_misaligned) begin
            w_code = c_code_align;
        end else if (w_upper_nz) begin
            w_code = c_code_range;
        end else begin
            w_code = c_code_ok;
        end
        w_fault = (w_code != c_code_ok);

        w_be       = w_be8[c_nb-1:0] << w_off;
        w_wdata_sh = req_wdata << w_shamt;
        for (int b = 0; b < c_nb; b++) begin
            w_merged[8*b +: 8] = w_be[b] ? w_wdata_sh[8*b +: 8] : w_cur[8*b +: 8];
        end
        w_rdata = (w_cur >> w_shamt) & w_dmask64[DATA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (w_accept && req_we && !w_fault) begin
            r_mem[w_index] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= '0;
            r_rsp_error    <= 1'b0;
            r_rsp_err_code <= c_code_ok;
            r_err_count    <= '0;
        end else if (w_accept) begin
            r_rsp_valid    <= 1'b1;
            r_rsp_rdata    <= (w_fault || req_we) ? '0 : w_rdata;
            r_rsp_error    <= w_fault;
            r_rsp_err_code <= w_code;
            if (w_fault && !(&r_err_count)) begin
                r_err_count <= r_err_count + ERRCNT_W'(1);
            end
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_error    = r_rsp_error;
    assign rsp_err_code = r_rsp_err_code;
    assign err_count    = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_aligned_mem_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_aligned_mem_port
// Brief    : Directed self-checking bench for aligned_mem_port (DATA_W=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aligned_mem_port;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int DEPTH    = 256;
    localparam int ERRCNT_W = 4;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [1:0]          req_size;
    logic [DATA_W-1:0]   req_wdata;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_error;
    logic [1:0]          rsp_err_code;
    logic [ERRCNT_W-1:0] err_count;

    int checks = 0;
    int errors = 0;

    aligned_mem_port #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ERRCNT_W (ERRCNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .rsp_err_code (rsp_err_code),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one request for a single cycle; outputs are sampled at the
    // falling edge after the accepting rising edge.
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = 2'd0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 ||
            rsp_err_code !== 2'd0 || err_count !== 4'd0) begin
            errors++;
            $display("FAIL reset: got v=%b d=%h e=%b c=%0d n=%0d exp all zero",
                     rsp_valid, rsp_rdata, rsp_error, rsp_err_code, err_count);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b exp 1", req_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        issue(1'b1, 32'h10, 2'd2, 32'hDEADBEEF);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL word_write: got v=%b e=%b d=%h exp v=1 e=0 d=0",
                     rsp_valid, rsp_error, rsp_rdata);
        end
        issue(1'b0, 32'h10, 2'd2, 32'h0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err_code !== 2'd0) begin
            errors++;
            $display("FAIL word_read: got v=%b d=%h c=%0d exp v=1 d=deadbeef c=0",
                     rsp_valid, rsp_rdata, rsp_err_code);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL word_drain: got rsp_valid %b exp 0", rsp_valid);
        end
    endtask

    task automatic test_subword();
        issue(1'b1, 32'h11, 2'd0, 32'h123456AA);
        issue(1'b0, 32'h10, 2'd2, 32'h0);
        checks++;
        if (rsp_rdata !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL byte_merge: got %h exp deadaaef", rsp_rdata);
        end
        issue(1'b0, 32'h12, 2'd1, 32'h0);
        checks++;
        if (rsp_rdata !== 32'h0000DEAD) begin
            errors++;
            $display("FAIL half_read: got %h exp 0000dead", rsp_rdata);
        end
        issue(1'b0, 32'h13, 2'd0, 32'h0);
        checks++;
        if (rsp_rdata !== 32'h000000DE) begin
            errors++;
            $display("FAIL byte_read: got %h exp 000000de", rsp_rdata);
        end
        issue(1'b1, 32'h3FC, 2'd2, 32'hCAFEF00D);
        issue(1'b0, 32'h3FC, 2'd2, 32'h0);
        checks++;
        if (rsp_rdata !== 32'hCAFEF00D || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL last_word: got d=%h e=%b exp cafef00d e=0", rsp_rdata, rsp_error);
        end
    endtask

    task automatic test_errors();
        issue(1'b1, 32'h13, 2'd2, 32'h12345678);
        checks++;
        if (rsp_error !== 1'b1 || rsp_err_code !== 2'd1 || err_count !== 4'd1 ||
            rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL misalign_write: got e=%b c=%0d n=%0d d=%h exp e=1 c=1 n=1 d=0",
                     rsp_error, rsp_err_code, err_count, rsp_rdata);
        end
        issue(1'b0, 32'h10, 2'd2, 32'h0);
        checks++;
        if (rsp_rdata !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL no_fault_write: got %h exp deadaaef", rsp_rdata);
        end
        issue(1'b0, 32'h11, 2'd1, 32'h0);
        checks++;
        if (rsp_err_code !== 2'd1 || err_count !== 4'd2 || rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL misalign_half: got c=%0d n=%0d d=%h exp c=1 n=2 d=0",
                     rsp_err_code, err_count, rsp_rdata);
        end
        issue(1'b0, 32'h400, 2'd2, 32'h0);
        checks++;
        if (rsp_err_code !== 2'd2 || rsp_error !== 1'b1 || err_count !== 4'd3) begin
            errors++;
            $display("FAIL range: got c=%0d e=%b n=%0d exp c=2 e=1 n=3",
                     rsp_err_code, rsp_error, err_count);
        end
        issue(1'b0, 32'h0, 2'd3, 32'h0);
        checks++;
        if (rsp_err_code !== 2'd3 || err_count !== 4'd4) begin
            errors++;
            $display("FAIL bad_size: got c=%0d n=%0d exp c=3 n=4", rsp_err_code, err_count);
        end
        issue(1'b0, 32'h1, 2'd3, 32'h0);
        checks++;
        if (rsp_err_code !== 2'd3 || err_count !== 4'd5) begin
            errors++;
            $display("FAIL size_priority: got c=%0d n=%0d exp c=3 n=5", rsp_err_code, err_count);
        end
        issue(1'b1, 32'h8000_0010, 2'd2, 32'h0);
        checks++;
        if (rsp_err_code !== 2'd2 || err_count !== 4'd6) begin
            errors++;
            $display("FAIL upper_bits: got c=%0d n=%0d exp c=2 n=6", rsp_err_code, err_count);
        end
        issue(1'b0, 32'h10, 2'd2, 32'h0);
        checks++;
        if (rsp_rdata !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL upper_no_alias: got %h exp deadaaef", rsp_rdata);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 12; i++) begin
            issue(1'b0, 32'h2, 2'd2, 32'h0);
        end
        checks++;
        if (err_count !== 4'hF) begin
            errors++;
            $display("FAIL saturate: got %0d exp 15", err_count);
        end
    endtask

    task automatic test_back_to_back();
        logic        b_we   [5];
        logic [31:0] b_addr [5];
        logic [1:0]  b_size [5];
        logic [31:0] b_wd   [5];
        logic [31:0] b_exp  [5];
        b_we[0] = 1'b0; b_addr[0] = 32'h12; b_size[0] = 2'd1; b_wd[0] = 32'h0;        b_exp[0] = 32'h0000DEAD;
        b_we[1] = 1'b1; b_addr[1] = 32'h20; b_size[1] = 2'd2; b_wd[1] = 32'h11223344; b_exp[1] = 32'h0;
        b_we[2] = 1'b0; b_addr[2] = 32'h20; b_size[2] = 2'd2; b_wd[2] = 32'h0;        b_exp[2] = 32'h11223344;
        b_we[3] = 1'b0; b_addr[3] = 32'h11; b_size[3] = 2'd0; b_wd[3] = 32'h0;        b_exp[3] = 32'h000000AA;
        b_we[4] = 1'b0; b_addr[4] = 32'h10; b_size[4] = 2'd2; b_wd[4] = 32'h0;        b_exp[4] = 32'hDEADAAEF;

        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2;
        @(negedge clk);
        req_we = b_we[0]; req_addr = b_addr[0]; req_size = b_size[0]; req_wdata = b_wd[0];
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADAAEF || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got v=%b d=%h r=%b exp v=1 d=deadaaef r=0",
                         i, rsp_valid, rsp_rdata, req_ready);
            end
            if (i < 2) @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_release: got %b exp 1", req_ready);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== b_exp[i] || rsp_error !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d: got v=%b d=%h e=%b exp v=1 d=%h e=0",
                         i, rsp_valid, rsp_rdata, rsp_error, b_exp[i]);
            end
            if (i < 4) begin
                req_we = b_we[i+1]; req_addr = b_addr[i+1];
                req_size = b_size[i+1]; req_wdata = b_wd[i+1];
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got %b exp 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || err_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b n=%0d exp v=0 n=0", rsp_valid, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        issue(1'b0, 32'h10, 2'd2, 32'h0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADAAEF) begin
            errors++;
            $display("FAIL mem_persist: got v=%b d=%h exp v=1 d=deadaaef", rsp_valid, rsp_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_saturate();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
